// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton debounce filter.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } key_fsm_e;

    // Synchronizer flops come out of reset in the released (high) level
    localparam logic SYNC_RST_VAL = 1'b1;

    function automatic logic is_down(input key_fsm_e s);
        return (s == HELD) || (s == RELEASE_DB);
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM and edge pulses.
// Optional long-press detector enabled by macro KEY_LONG_PRESS_EN.
module key_filter_ch
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_reg <= SYNC_RST_VAL;
            sync2_reg <= SYNC_RST_VAL;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    key_fsm_e                    state_reg, state_next;
    logic [$bits(CNT_MAX)-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter stops at CNT_MAX because reaching it always leaves the state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (!sync2_reg) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (sync2_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (sync2_reg) begin
                    state_next = RELEASE_DB;
                    cnt_next   = '0;
                end
            end
            RELEASE_DB: begin
                if (!sync2_reg) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    logic down_next;
    logic key_state_reg;
    logic key_press_reg;
    logic key_release_reg;

    assign down_next = is_down(state_next);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_state_reg   <= 1'b0;
            key_press_reg   <= 1'b0;
            key_release_reg <= 1'b0;
        end else begin
            key_state_reg   <= down_next;
            key_press_reg   <= down_next & ~key_state_reg;
            key_release_reg <= ~down_next & key_state_reg;
        end
    end

    assign key_state   = key_state_reg;
    assign key_press   = key_press_reg;
    assign key_release = key_release_reg;

`ifdef KEY_LONG_PRESS_EN
    logic [$bits(LONG_MAX)-1:0] long_cnt_reg;
    logic                       long_done_reg;
    logic                       key_long_reg;

    // Count only while HELD; bounces through RELEASE_DB pause but keep the count
    always_ff @(posedge sys_clk) begin
        if (sys_rst || state_reg == IDLE) begin
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            key_long_reg  <= 1'b0;
        end else begin
            key_long_reg <= 1'b0;
            if (state_reg == HELD && !long_done_reg) begin
                if (long_cnt_reg == LONG_MAX) begin
                    key_long_reg  <= 1'b1;
                    long_done_reg <= 1'b1;
                end else begin
                    long_cnt_reg <= long_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign key_long = key_long_reg;
`else
    assign key_long = 1'b0 & (|LONG_MAX);
`endif

endmodule

// File: rtl/key_filter_top.sv
// Four independent debounced pushbutton channels.
// Long-press pulses exist only when macro KEY_LONG_PRESS_EN is defined.
module key_filter_top
    import key_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            key_filter_ch #(
                .CNT_MAX  (CNT_MAX),
                .LONG_MAX (LONG_MAX)
            ) u_ch (
                .sys_clk     (sys_clk),
                .sys_rst     (sys_rst),
                .key_in      (key_in[gi]),
                .key_state   (key_state[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi]),
                .key_long    (key_long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_filter_top.sv
// Self-checking bench for key_filter_top: table vectors, directed corners, random vs model.
module tb_key_filter_top;

    localparam int CNT  = 4;
    localparam int LONG = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam logic [3:0] LONG_CHK = 4'h0;
    localparam int         LONG_EXP = 1;
`else
    localparam logic [3:0] LONG_CHK = 4'hF;
    localparam int         LONG_EXP = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] key_in;
    logic [3:0] key_state, key_press, key_release, key_long;

    key_filter_top #(
        .CNT_MAX  (20'(CNT)),
        .LONG_MAX (26'(LONG))
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_step = 0;

    // Reference: debounced level flips after CNT+2 consecutive effective samples
    // disagreeing with it; the effective sample is key_in two edges back, forced
    // high for two edges after any reset edge.
    logic [3:0] m_state;
    logic [3:0] m_press, m_rel;
    int         m_run [4];
    logic [3:0] h_key0 = 4'hF, h_key1 = 4'hF;
    logic       h_rst0 = 1'b1, h_rst1 = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] k);
        logic [3:0] s;
        sys_rst = rst;
        key_in  = k;
        @(posedge sys_clk);
        #1;
        n_step++;
        s = (h_rst0 | h_rst1) ? 4'hF : h_key1;
        h_key1 = h_key0; h_key0 = k;
        h_rst1 = h_rst0; h_rst0 = rst;
        m_press = 4'h0;
        m_rel   = 4'h0;
        if (rst) begin
            m_state = 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s[i] == m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == CNT + 2) begin
                        m_run[i]   = 0;
                        m_state[i] = ~m_state[i];
                        if (m_state[i]) m_press[i] = 1'b1;
                        else            m_rel[i]   = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        $display("step %0d rst=%0b key_in=%h -> state=%h press=%h release=%h long=%h",
                 n_step, rst, k, key_state, key_press, key_release, key_long);
        check("model", {16'h0, key_state, key_press, key_release, key_long & LONG_CHK},
              {16'h0, m_state, m_press, m_rel, 4'h0});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'hF);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t row(input logic r, input logic [3:0] k, input logic [3:0] st,
                                 input logic [3:0] pr, input logic [3:0] rl);
        vec_t v;
        v.rst = r; v.key = k; v.st = st; v.pr = pr; v.rl = rl;
        return v;
    endfunction

    initial begin
        int cnt_a, cnt_b, hit, bad;
        logic [3:0] k;

        // Clean press then clean release on key 0 (edge 0 = table row 2)
        tbl[0] = row(1, 4'hF, 4'h0, 4'h0, 4'h0);
        tbl[1] = row(1, 4'hF, 4'h0, 4'h0, 4'h0);
        for (int i = 2; i <= 8; i++) tbl[i] = row(0, 4'hE, 4'h0, 4'h0, 4'h0);
        tbl[9]  = row(0, 4'hE, 4'h1, 4'h1, 4'h0);
        tbl[10] = row(0, 4'hE, 4'h1, 4'h0, 4'h0);
        for (int i = 11; i <= 17; i++) tbl[i] = row(0, 4'hF, 4'h1, 4'h0, 4'h0);
        tbl[18] = row(0, 4'hF, 4'h0, 4'h0, 4'h1);
        tbl[19] = row(0, 4'hF, 4'h0, 4'h0, 4'h0);

        sys_rst = 1'b1;
        key_in  = 4'hF;
        m_state = 4'h0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].key);
            check($sformatf("table_row%0d", i),
                  {16'h0, key_state, key_press, key_release, key_long},
                  {16'h0, tbl[i].st, tbl[i].pr, tbl[i].rl, 4'h0});
        end

        // Glitch on key 1 shorter than the debounce window
        idle(4);
        cnt_a = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 4'hD);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'hF);
            if (key_press[1] || key_release[1] || key_state[1]) cnt_a++;
        end
        check("glitch_activity", cnt_a, 0);

        // Bouncing release on key 2
        for (int i = 0; i < 10; i++) step(1'b0, 4'hB);
        check("bounce_held", {31'h0, key_state[2]}, 1);
        cnt_a = 0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 2; i++) begin step(1'b0, 4'hF); cnt_a += key_release[2]; end
            for (int i = 0; i < 2; i++) begin step(1'b0, 4'hB); cnt_a += key_release[2]; end
        end
        hit = -1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 4'hF);
            cnt_a += key_release[2];
            if (key_release[2]) hit = i;
        end
        check("bounce_release_count", cnt_a, 1);
        check("bounce_release_edge", hit, CNT + 3);

        // Long press on key 3
        idle(4);
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin step(1'b0, 4'h7); cnt_a += key_long[3]; end
        for (int i = 0; i < 12; i++) begin step(1'b0, 4'hF); cnt_a += key_long[3]; end
        check("long_pulses", cnt_a, LONG_EXP);

        // Reset in the middle of a press debounce, key kept down
        idle(4);
        for (int i = 0; i < 4; i++) step(1'b0, 4'hE);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'hE);
            check("reset_outputs", {16'h0, key_state, key_press, key_release, key_long}, 0);
        end
        cnt_a = 0; hit = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'hE);
            cnt_a += key_press[0];
            if (key_press[0]) hit = i;
        end
        check("reset_press_count", cnt_a, 1);
        check("reset_press_edge", hit, CNT + 3);

        // All four keys together
        idle(10);
        hit = -1; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'h0);
            if (key_press == 4'hF) hit = i;
            else if (key_press != 4'h0) bad++;
        end
        check("simul_press_edge", hit, CNT + 3);
        check("simul_partial", bad, 0);
        idle(10);

        // Random bursty stimulus with occasional resets
        k = 4'hF;
        cnt_b = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) k[b] = ~k[b];
            step($urandom_range(0, 399) == 0, k);
            cnt_b += $countones(key_press);
        end
        $display("random phase saw %0d press pulses", cnt_b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
